// File: rtl/fitness_evaluator_pkg.sv
// Shared definitions for the genetic-algorithm fitness loop: instruction
// geometry of the fitness unit and the evaluator state encoding.
package fitness_evaluator_pkg;

    localparam int OpcodeWidth        = 16;
    localparam int OpCounterWidth     = 2;
    localparam int GaInstructionWidth = OpcodeWidth * (2 ** OpCounterWidth);
    localparam int GaErrorWidth       = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } evalState_e;

endpackage

// File: rtl/fitness_evaluator_if.sv
// Start/finish handshake between the evaluator (master) and the fitness unit (slave).
interface fitness_evaluator_if
    import fitness_evaluator_pkg::*;
#(
    parameter int InstructionWidth = GaInstructionWidth,
    parameter int ErrorWidth       = GaErrorWidth
);

    logic [InstructionWidth-1:0] fit_individual;
    logic                        fit_start;
    logic [ErrorWidth-1:0]       fit_error;
    logic                        fit_finish;
    logic                        fit_buzy;

    modport master (
        output fit_individual,
        output fit_start,
        input  fit_error,
        input  fit_finish,
        input  fit_buzy
    );

    modport slave (
        input  fit_individual,
        input  fit_start,
        output fit_error,
        output fit_finish,
        output fit_buzy
    );

endinterface

// File: rtl/fitness_evaluator_min_tracker.sv
// Registered running minimum: keeps the smallest value seen since the last
// clear, with the index and payload that produced it. Ties keep the older entry.
module ga_min_tracker
    import fitness_evaluator_pkg::*;
#(
    parameter int ValueWidth   = GaErrorWidth,
    parameter int IndexWidth   = 3,
    parameter int PayloadWidth = GaInstructionWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    update_i,
    input  logic [ValueWidth-1:0]   value_i,
    input  logic [IndexWidth-1:0]   index_i,
    input  logic [PayloadWidth-1:0] payload_i,
    output logic [ValueWidth-1:0]   best_value_o,
    output logic [IndexWidth-1:0]   best_index_o,
    output logic [PayloadWidth-1:0] best_payload_o
);

    logic [ValueWidth-1:0]   bestValue_q;
    logic [IndexWidth-1:0]   bestIndex_q;
    logic [PayloadWidth-1:0] bestPayload_q;

    // Clear restarts the search but keeps the payload; a strictly smaller value replaces the record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bestValue_q   <= '1;
            bestIndex_q   <= '0;
            bestPayload_q <= '0;
        end else if (clear_i) begin
            bestValue_q <= '1;
            bestIndex_q <= '0;
        end else if (update_i && (value_i < bestValue_q)) begin
            bestValue_q   <= value_i;
            bestIndex_q   <= index_i;
            bestPayload_q <= payload_i;
        end
    end

    assign best_value_o   = bestValue_q;
    assign best_index_o   = bestIndex_q;
    assign best_payload_o = bestPayload_q;

endmodule

// File: rtl/fitness_evaluator.sv
// Sequencer that walks the stored population through the fitness unit one
// individual at a time, records every error and tracks the best individual.
module fitness_evaluator
    import fitness_evaluator_pkg::*;
#(
    parameter int PopulationSize   = 8,
    parameter int InstructionWidth = GaInstructionWidth,
    parameter int ErrorWidth       = GaErrorWidth,
    parameter int IndexWidth       = $clog2(PopulationSize)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        pop_we,
    input  logic [IndexWidth-1:0]       pop_waddr,
    input  logic [InstructionWidth-1:0] pop_wdata,
    fitness_evaluator_if.master         fit,
    input  logic [IndexWidth-1:0]       err_raddr,
    output logic [ErrorWidth-1:0]       err_rdata,
    output logic [IndexWidth-1:0]       best_index,
    output logic [ErrorWidth-1:0]       best_error,
    output logic [InstructionWidth-1:0] best_individual,
    output logic                        done,
    output logic                        buzy
);

    localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(PopulationSize - 1);

    evalState_e                  state_q;
    logic [IndexWidth-1:0]       index_q;
    logic                        fitStart_q;
    logic                        done_q;
    logic                        finishPrev_q;
    logic [InstructionWidth-1:0] popMem_q [PopulationSize];
    logic [ErrorWidth-1:0]       errMem_q [PopulationSize];
    logic                        capture;
    logic                        clearBest;

    // A finish only counts on its rising edge, so a level left high by the
    // previous individual is never taken as the current one's result.
    assign capture   = (state_q == WAIT) && fit.fit_finish && !finishPrev_q;
    assign clearBest = (state_q == IDLE) && run;
    assign buzy      = (state_q != IDLE);

    // Sequencer FSM: issue, wait for the result, advance, then pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            fitStart_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fitStart_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        index_q <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!fit.fit_buzy) begin
                        fitStart_q <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        if (index_q == LastIndex) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + IndexWidth'(1);
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Registered copy of the finish level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finishPrev_q <= 1'b0;
        end else begin
            finishPrev_q <= fit.fit_finish;
        end
    end

    // Per-individual error store; unevaluated entries read as the worst error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PopulationSize; i++) begin
                errMem_q[i] <= '1;
            end
        end else if (capture) begin
            errMem_q[index_q] <= fit.fit_error;
        end
    end

    // Population store, writable only while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (pop_we && !buzy) begin
            popMem_q[pop_waddr] <= pop_wdata;
        end
    end

    ga_min_tracker #(
        .ValueWidth   (ErrorWidth),
        .IndexWidth   (IndexWidth),
        .PayloadWidth (InstructionWidth)
    ) uMinTracker (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clearBest),
        .update_i       (capture),
        .value_i        (fit.fit_error),
        .index_i        (index_q),
        .payload_i      (popMem_q[index_q]),
        .best_value_o   (best_error),
        .best_index_o   (best_index),
        .best_payload_o (best_individual)
    );

    assign fit.fit_individual = popMem_q[index_q];
    assign fit.fit_start      = fitStart_q;
    assign err_rdata          = errMem_q[err_raddr];
    assign done               = done_q;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Self-checking bench for fitness_evaluator with a behavioural fitness unit.
module tb_fitness_evaluator;
    import fitness_evaluator_pkg::*;

    localparam int PopSize = 8;
    localparam int IdxW    = 3;
    localparam int InstW   = GaInstructionWidth;
    localparam int ErrW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run = 1'b0;
    logic             pop_we = 1'b0;
    logic [IdxW-1:0]  pop_waddr = '0;
    logic [InstW-1:0] pop_wdata = '0;
    logic [IdxW-1:0]  err_raddr = '0;
    logic [ErrW-1:0]  err_rdata;
    logic [IdxW-1:0]  best_index;
    logic [ErrW-1:0]  best_error;
    logic [InstW-1:0] best_individual;
    logic             done;
    logic             buzy;

    fitness_evaluator_if #(.InstructionWidth(InstW), .ErrorWidth(ErrW)) fit ();

    fitness_evaluator #(
        .PopulationSize   (PopSize),
        .InstructionWidth (InstW),
        .ErrorWidth       (ErrW),
        .IndexWidth       (IdxW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .pop_we          (pop_we),
        .pop_waddr       (pop_waddr),
        .pop_wdata       (pop_wdata),
        .fit             (fit.master),
        .err_raddr       (err_raddr),
        .err_rdata       (err_rdata),
        .best_index      (best_index),
        .best_error      (best_error),
        .best_individual (best_individual),
        .done            (done),
        .buzy            (buzy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Test-owned configuration and reference data
    int               cfgLatency = 3;
    int               cfgBusy = 0;
    bit               cfgHold = 1'b0;
    int               startBase = 0;
    logic [InstW-1:0] popModel [PopSize];
    logic [ErrW-1:0]  errTable [PopSize];
    logic [InstW-1:0] refIndiv = '0;
    logic [ErrW-1:0]  refErr;
    int               refIdx;

    // Model-owned observations
    logic [InstW-1:0] startLog [$];
    int               startCount = 0;
    int               startWhileBusy = 0;
    int               spuriousStart = 0;
    int               unstable = 0;
    int               doneCount = 0;

    // Behavioural fitness unit: answers each start after cfgLatency cycles with
    // the next error of the table, optionally holding finish and raising busy.
    initial begin
        int               countdown;
        int               busyLeft;
        int               k;
        bit               prevDutBuzy;
        bit               prevStart;
        logic [InstW-1:0] curIndiv;
        logic [ErrW-1:0]  curErr;
        countdown = 0;
        busyLeft = 0;
        prevDutBuzy = 1'b0;
        prevStart = 1'b0;
        curIndiv = '0;
        curErr = '0;
        fit.fit_finish = 1'b0;
        fit.fit_error = '0;
        fit.fit_buzy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fit.fit_finish = 1'b0;
                fit.fit_buzy = 1'b0;
                countdown = 0;
                busyLeft = 0;
                prevDutBuzy = 1'b0;
                prevStart = 1'b0;
            end else begin
                if (fit.fit_start && fit.fit_buzy) startWhileBusy++;
                if (fit.fit_start && (countdown > 0 || prevStart)) spuriousStart++;
                if (countdown > 0 && fit.fit_individual !== curIndiv) unstable++;
                if (fit.fit_finish && !cfgHold) fit.fit_finish = 1'b0;
                if (busyLeft > 0) begin
                    busyLeft--;
                    if (busyLeft == 0) fit.fit_buzy = 1'b0;
                end
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        fit.fit_finish = 1'b1;
                        fit.fit_error = curErr;
                        if (cfgBusy > 0) begin
                            fit.fit_buzy = 1'b1;
                            busyLeft = cfgBusy;
                        end
                    end
                end
                if (buzy && !prevDutBuzy && cfgBusy > 0) begin
                    fit.fit_buzy = 1'b1;
                    busyLeft = cfgBusy;
                end
                if (fit.fit_start) begin
                    startLog.push_back(fit.fit_individual);
                    startCount++;
                    curIndiv = fit.fit_individual;
                    k = startCount - startBase - 1;
                    curErr = (k >= 0 && k < PopSize) ? errTable[k] : '0;
                    countdown = cfgLatency;
                    if (cfgHold) fit.fit_finish = 1'b0;
                end
                prevDutBuzy = buzy;
                prevStart = fit.fit_start;
            end
        end
    end

    // Done pulse counter
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
    end

    // Global watchdog
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Best = smallest error, earliest index among equals; payload only moves
    // when something beats the all-ones starting value.
    function automatic void computeReference();
        logic [ErrW-1:0] minVal;
        minVal = '1;
        for (int i = 0; i < PopSize; i++) if (errTable[i] < minVal) minVal = errTable[i];
        refErr = minVal;
        refIdx = 0;
        for (int i = PopSize - 1; i >= 0; i--) if (errTable[i] == minVal) refIdx = i;
        if (minVal != '1) refIndiv = popModel[refIdx];
    endfunction

    function automatic logic [InstW-1:0] loggedStart(input int n);
        int idx;
        idx = startBase + n;
        return (idx < startLog.size()) ? startLog[idx] : 'x;
    endfunction

    task automatic resetDut();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        refIndiv = '0;
        @(negedge clk);
        #1;
    endtask

    task automatic randomizeGeneration();
        for (int i = 0; i < PopSize; i++) begin
            popModel[i] = {$urandom, $urandom};
            errTable[i] = ErrW'($urandom_range(0, 31));
        end
    endtask

    task automatic loadPopulation();
        for (int i = 0; i < PopSize; i++) begin
            @(negedge clk);
            pop_we = 1'b1;
            pop_waddr = IdxW'(i);
            pop_wdata = popModel[i];
        end
        @(negedge clk);
        pop_we = 1'b0;
    endtask

    task automatic startRun();
        startBase = startCount;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic waitStarts(input int n, output bit timedOut);
        for (int c = 0; c < 1000; c++) begin
            if (startCount - startBase >= n) break;
            @(negedge clk);
            #1;
        end
        timedOut = (startCount - startBase < n);
    endtask

    task automatic waitDone(input int base, output bit timedOut);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #1;
            if (doneCount != base) break;
        end
        timedOut = (doneCount == base);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if (buzy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.buzy got %b expected 0", buzy); end
        vectors++;
        if (fit.fit_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.fit_start got %b expected 0", fit.fit_start); end
        resetDut();
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (buzy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle.buzy got %b expected 0", buzy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL idle.done got %b expected 0", done); end
        vectors++;
        if (fit.fit_start !== 1'b0) begin miscompares++; $display("[TB] FAIL idle.fit_start got %b expected 0", fit.fit_start); end
        vectors++;
        if (best_error !== 5'h1F) begin miscompares++; $display("[TB] FAIL idle.best_error got %h expected 1f", best_error); end
        vectors++;
        if (best_index !== '0) begin miscompares++; $display("[TB] FAIL idle.best_index got %0d expected 0", best_index); end
        vectors++;
        if (best_individual !== '0) begin miscompares++; $display("[TB] FAIL idle.best_individual got %h expected 0", best_individual); end
        for (int i = 0; i < PopSize; i++) begin
            err_raddr = IdxW'(i);
            #1;
            vectors++;
            if (err_rdata !== 5'h1F) begin miscompares++; $display("[TB] FAIL idle.err_rdata[%0d] got %h expected 1f", i, err_rdata); end
        end
    endtask

    task automatic test_full_generation();
        bit timedOut;
        int doneBase;
        logic [ErrW-1:0] table0 [PopSize] = '{5'd9, 5'd3, 5'd7, 5'd3, 5'd12, 5'd31, 5'd20, 5'd4};
        cfgLatency = 3; cfgBusy = 0; cfgHold = 1'b0;
        for (int i = 0; i < PopSize; i++) begin
            popModel[i] = InstW'(i);
            errTable[i] = table0[i];
        end
        loadPopulation();
        doneBase = doneCount;
        startRun();
        waitDone(doneBase, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL full.done_timeout got none expected pulse"); end
        vectors++;
        if (startCount - startBase !== 8) begin miscompares++; $display("[TB] FAIL full.starts got %0d expected 8", startCount - startBase); end
        vectors++;
        if (doneCount - doneBase !== 1) begin miscompares++; $display("[TB] FAIL full.done_count got %0d expected 1", doneCount - doneBase); end
        for (int i = 0; i < PopSize; i++) begin
            vectors++;
            if (loggedStart(i) !== popModel[i]) begin miscompares++; $display("[TB] FAIL full.issued[%0d] got %h expected %h", i, loggedStart(i), popModel[i]); end
        end
        vectors++;
        if (best_index !== 3'd1) begin miscompares++; $display("[TB] FAIL full.best_index got %0d expected 1", best_index); end
        vectors++;
        if (best_error !== 5'd3) begin miscompares++; $display("[TB] FAIL full.best_error got %0d expected 3", best_error); end
        vectors++;
        if (best_individual !== 64'h1) begin miscompares++; $display("[TB] FAIL full.best_individual got %h expected 1", best_individual); end
        refIndiv = 64'h1;
        for (int i = 0; i < PopSize; i++) begin
            err_raddr = IdxW'(i);
            #1;
            vectors++;
            if (err_rdata !== errTable[i]) begin miscompares++; $display("[TB] FAIL full.err_rdata[%0d] got %0d expected %0d", i, err_rdata, errTable[i]); end
        end
        vectors++;
        if (buzy !== 1'b0) begin miscompares++; $display("[TB] FAIL full.buzy_after got %b expected 0", buzy); end
    endtask

    task automatic test_busy_handshake();
        bit timedOut;
        int doneBase, wbBase, spBase, unBase;
        cfgLatency = 3; cfgBusy = 5; cfgHold = 1'b0;
        randomizeGeneration();
        loadPopulation();
        computeReference();
        doneBase = doneCount; wbBase = startWhileBusy; spBase = spuriousStart; unBase = unstable;
        startRun();
        waitDone(doneBase, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL busy.done_timeout got none expected pulse"); end
        vectors++;
        if (startCount - startBase !== 8) begin miscompares++; $display("[TB] FAIL busy.starts got %0d expected 8", startCount - startBase); end
        vectors++;
        if (startWhileBusy - wbBase !== 0) begin miscompares++; $display("[TB] FAIL busy.start_while_busy got %0d expected 0", startWhileBusy - wbBase); end
        vectors++;
        if (spuriousStart - spBase !== 0) begin miscompares++; $display("[TB] FAIL busy.extra_start got %0d expected 0", spuriousStart - spBase); end
        vectors++;
        if (unstable - unBase !== 0) begin miscompares++; $display("[TB] FAIL busy.individual_unstable got %0d expected 0", unstable - unBase); end
        for (int i = 0; i < PopSize; i++) begin
            vectors++;
            if (loggedStart(i) !== popModel[i]) begin miscompares++; $display("[TB] FAIL busy.issued[%0d] got %h expected %h", i, loggedStart(i), popModel[i]); end
        end
        vectors++;
        if (best_error !== refErr || best_index !== IdxW'(refIdx) || best_individual !== refIndiv) begin
            miscompares++;
            $display("[TB] FAIL busy.best got %0d/%0d/%h expected %0d/%0d/%h", best_error, best_index, best_individual, refErr, refIdx, refIndiv);
        end
        cfgBusy = 0;
    endtask

    task automatic test_held_finish();
        bit timedOut;
        int doneBase;
        cfgLatency = int'($urandom_range(2, 5)); cfgBusy = 0; cfgHold = 1'b1;
        randomizeGeneration();
        loadPopulation();
        computeReference();
        doneBase = doneCount;
        startRun();
        waitDone(doneBase, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL hold.done_timeout got none expected pulse"); end
        vectors++;
        if (startCount - startBase !== 8) begin miscompares++; $display("[TB] FAIL hold.starts got %0d expected 8", startCount - startBase); end
        vectors++;
        if (doneCount - doneBase !== 1) begin miscompares++; $display("[TB] FAIL hold.done_count got %0d expected 1", doneCount - doneBase); end
        for (int i = 0; i < PopSize; i++) begin
            err_raddr = IdxW'(i);
            #1;
            vectors++;
            if (err_rdata !== errTable[i]) begin miscompares++; $display("[TB] FAIL hold.err_rdata[%0d] got %0d expected %0d", i, err_rdata, errTable[i]); end
        end
        vectors++;
        if (best_error !== refErr || best_index !== IdxW'(refIdx) || best_individual !== refIndiv) begin
            miscompares++;
            $display("[TB] FAIL hold.best got %0d/%0d/%h expected %0d/%0d/%h", best_error, best_index, best_individual, refErr, refIdx, refIndiv);
        end
        cfgHold = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        bit timedOut;
        int doneBase;
        cfgLatency = 6; cfgBusy = 0; cfgHold = 1'b0;
        randomizeGeneration();
        loadPopulation();
        computeReference();
        doneBase = doneCount;
        startRun();
        waitStarts(3, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL ignore.start_timeout got %0d expected 3", startCount - startBase); end
        pop_we = 1'b1;
        pop_waddr = IdxW'($urandom_range(0, PopSize - 1));
        pop_wdata = 64'hFFFF;
        run = 1'b1;
        @(negedge clk);
        pop_we = 1'b0;
        run = 1'b0;
        waitDone(doneBase, timedOut);
        repeat (40) @(negedge clk);
        #1;
        vectors++;
        if (doneCount - doneBase !== 1) begin miscompares++; $display("[TB] FAIL ignore.done_count got %0d expected 1", doneCount - doneBase); end
        vectors++;
        if (buzy !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore.buzy got %b expected 0", buzy); end
        vectors++;
        if (startCount - startBase !== 8) begin miscompares++; $display("[TB] FAIL ignore.starts got %0d expected 8", startCount - startBase); end
        vectors++;
        if (best_error !== refErr || best_index !== IdxW'(refIdx) || best_individual !== refIndiv) begin
            miscompares++;
            $display("[TB] FAIL ignore.best got %0d/%0d/%h expected %0d/%0d/%h", best_error, best_index, best_individual, refErr, refIdx, refIndiv);
        end
        // A second pass shows the population survived the blocked write
        doneBase = doneCount;
        startRun();
        waitDone(doneBase, timedOut);
        for (int i = 0; i < PopSize; i++) begin
            vectors++;
            if (loggedStart(i) !== popModel[i]) begin miscompares++; $display("[TB] FAIL ignore.pop_mem[%0d] got %h expected %h", i, loggedStart(i), popModel[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit timedOut;
        int doneBase;
        cfgLatency = 4; cfgBusy = 0; cfgHold = 1'b0;
        randomizeGeneration();
        loadPopulation();
        startRun();
        waitStarts(5, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL midreset.start_timeout got %0d expected 5", startCount - startBase); end
        err_raddr = '0;
        rst = 1'b0;
        #1;
        vectors++;
        if (buzy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset.buzy got %b expected 0", buzy); end
        vectors++;
        if (fit.fit_start !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset.fit_start got %b expected 0", fit.fit_start); end
        vectors++;
        if (best_error !== 5'h1F) begin miscompares++; $display("[TB] FAIL midreset.best_error got %h expected 1f", best_error); end
        vectors++;
        if (best_individual !== '0) begin miscompares++; $display("[TB] FAIL midreset.best_individual got %h expected 0", best_individual); end
        vectors++;
        if (err_rdata !== 5'h1F) begin miscompares++; $display("[TB] FAIL midreset.err_rdata[0] got %h expected 1f", err_rdata); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        refIndiv = '0;
        computeReference();
        doneBase = doneCount;
        startRun();
        waitDone(doneBase, timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL midreset.done_timeout got none expected pulse"); end
        for (int i = 0; i < PopSize; i++) begin
            vectors++;
            if (loggedStart(i) !== popModel[i]) begin miscompares++; $display("[TB] FAIL midreset.issued[%0d] got %h expected %h", i, loggedStart(i), popModel[i]); end
        end
        vectors++;
        if (best_error !== refErr || best_index !== IdxW'(refIdx) || best_individual !== refIndiv) begin
            miscompares++;
            $display("[TB] FAIL midreset.best got %0d/%0d/%h expected %0d/%0d/%h", best_error, best_index, best_individual, refErr, refIdx, refIndiv);
        end
    endtask

    task automatic test_random_generations();
        bit timedOut;
        int doneBase;
        for (int g = 0; g < 4; g++) begin
            cfgLatency = int'($urandom_range(1, 6));
            cfgBusy = int'($urandom_range(0, 3));
            cfgHold = 1'($urandom_range(0, 1));
            randomizeGeneration();
            loadPopulation();
            computeReference();
            doneBase = doneCount;
            startRun();
            waitDone(doneBase, timedOut);
            vectors++;
            if (timedOut || startCount - startBase !== 8) begin
                miscompares++;
                $display("[TB] FAIL rand%0d.starts got %0d expected 8 (timeout %b)", g, startCount - startBase, timedOut);
            end
            vectors++;
            if (best_error !== refErr || best_index !== IdxW'(refIdx) || best_individual !== refIndiv) begin
                miscompares++;
                $display("[TB] FAIL rand%0d.best got %0d/%0d/%h expected %0d/%0d/%h", g, best_error, best_index, best_individual, refErr, refIdx, refIndiv);
            end
            for (int i = 0; i < PopSize; i++) begin
                err_raddr = IdxW'(i);
                #1;
                vectors++;
                if (err_rdata !== errTable[i]) begin miscompares++; $display("[TB] FAIL rand%0d.err_rdata[%0d] got %0d expected %0d", g, i, err_rdata, errTable[i]); end
            end
        end
        cfgHold = 1'b0;
        cfgBusy = 0;
    endtask

    initial begin
        test_reset();
        test_full_generation();
        test_busy_handshake();
        test_held_finish();
        test_ignored_inputs();
        test_reset_mid_run();
        test_random_generations();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fitness_evaluator.md
Name: fitness_evaluator

Overview:
Downstream sequencer for the morphologic fitness stage. Holds a population of individuals and issues each one in turn to the fitness unit using its start/finish handshake. Captures every returned error and tracks the best individual, meaning the one with minimum error. Feeds the selection/crossover stage of the genetic loop.

Parameters:
PopulationSize, 8, number of individuals per generation (power of two, >=2)
InstructionWidth, 64, width of one individual; matches the fitness unit (16-bit opcode x 4)
ErrorWidth, 5, width of the error returned by the fitness unit
IndexWidth, $clog2(PopulationSize), width of an individual index

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  starts evaluation of the whole population; sampled only in IDLE
pop_we  in  1  population write enable
pop_waddr  in  IndexWidth  population write index
pop_wdata  in  InstructionWidth  individual to store
fit_individual  out  InstructionWidth  individual presented to the fitness unit
fit_start  out  1  start pulse to the fitness unit
fit_error  in  ErrorWidth  error from the fitness unit
fit_finish  in  1  completion flag from the fitness unit
fit_buzy  in  1  fitness unit busy
err_raddr  in  IndexWidth  error readback index
err_rdata  out  ErrorWidth  stored error of individual err_raddr (combinational read)
best_index  out  IndexWidth  index of the lowest-error individual
best_error  out  ErrorWidth  its error
best_individual  out  InstructionWidth  its genome, registered copy
done  out  1  one-cycle pulse when the generation has been evaluated
buzy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; index=0.
  - fit_start=0, done=0, buzy=0.
  - best_index=0, best_error=all ones, best_individual=0.
  - Every err_mem entry=all ones. Population contents are not reset.
- Population writes:
  - Accepted only when buzy=0.
  - pop_we while buzy=1 is ignored.
- fit_individual is always pop_mem[index]. It stays stable from ISSUE until the finish is captured.
- FSM states and transitions:
  - IDLE: on run=1, set index=0, best_error=all ones, best_index=0, then go to ISSUE.
  - ISSUE: wait while fit_buzy=1. When fit_buzy=0, drive fit_start=1 for exactly one cycle and go to WAIT.
  - WAIT: detect a fit_finish rising edge using a registered copy of fit_finish, reset to 0. A level held high from a previous individual is never counted twice. On the edge:
    - write fit_error into err_mem[index];
    - if fit_error < best_error (strict), update best_error, best_index and best_individual.
    - Ties keep the earlier index.
    - If index==PopulationSize-1, go to DONE; otherwise increment index and go to ISSUE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: per individual, 1 ISSUE cycle (if fit_buzy=0) plus the fitness latency plus 1 capture cycle. The done pulse follows the last capture by 1 cycle.
- run while buzy=1 is ignored; there is no restart mid-generation.
- The best_* outputs hold their values in IDLE until the next run.
- Reset mid-generation: aborts immediately, fit_start drops, all outputs return to reset values. The fitness unit is expected to share rst.
- No timeout: a fitness unit that never finishes leaves the block in WAIT until reset.

Decomposition:
- Shared GA package holds:
  - state encoding localparams (IDLE, ISSUE, WAIT, DONE);
  - the opcode/instruction width constants already used by the fitness unit, so InstructionWidth=OpcodeWidth*2**OpCounterWidth is derived in one place.
- One natural sub-module: ga_min_tracker.
  - Registered running-minimum comparator.
  - Holds best value, index and payload.
  - Has clear and strict-less-than update inputs.
- Population and error storage are plain register arrays inside fitness_evaluator.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 pulse, no run.
  - Response: buzy=0, done=0, fit_start=0, best_error=5'h1F, err_rdata=5'h1F for every address.
- Full generation with a behavioural fitness model (finish 3 cycles after start):
  - Stimulus: load individuals 0..7 = 64'h0..7; model errors {9,3,7,3,12,31,20,4}.
  - Response: exactly 8 fit_start pulses; done once; best_index=1 (tie with index 3 keeps 1); best_error=3; best_individual=64'h1; err_rdata readback matches all 8.
- Handshake under busy:
  - Stimulus: hold fit_buzy=1 for 5 cycles at each ISSUE.
  - Response: fit_start stays 0 until fit_buzy=0, then one pulse; fit_individual stable throughout.
- Held finish level:
  - Stimulus: model keeps fit_finish=1 between individuals until the next start.
  - Response: each error captured exactly once; 8 captures total.
- Ignored inputs:
  - Stimulus: pop_we with 64'hFFFF and a run pulse during WAIT of individual 2.
  - Response: pop_mem unchanged; no second generation; done pulses once.
- Reset mid-run:
  - Stimulus: rst=0 while in WAIT of individual 4.
  - Response: buzy=0, fit_start=0, best_error=5'h1F immediately (asynchronous); a new run evaluates from index 0.
